// File: rtl/alu_serial_sequencer.sv
// Bit-serial sequencer driving one external 1-bit ALU slice, LSB first, with carry fed back each cycle.
// Optional build macro OVERFLOW_FLAG_EN adds the out_ovf port (signed overflow for ADD/SUB).
//
// state   | meaning
// IDLE    | ready for a command; in_ready=1
// RUN     | slice is driven one bit per cycle, WIDTH cycles
// DONE    | result/err held until out_ready
module alu_serial_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_err,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_cin,
   output logic [2:0]       slice_cntrl,
   input  logic             slice_out,
   input  logic             slice_cout
`ifdef OVERFLOW_FLAG_EN
   ,
   output logic             out_ovf
`endif
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_SLT = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic [2:0]       r_op;
   logic [CNTW-1:0]  r_cnt;
   logic             r_carry;
   logic             r_err;
   logic             w_last;
   logic             w_ovf;
   logic             w_is_sub;
`ifdef OVERFLOW_FLAG_EN
   logic             r_ovf;
`endif

   assign w_last   = (r_cnt == CNTW'(WIDTH - 1));
   // On the MSB cycle r_carry is the carry into the MSB, so this is the signed overflow.
   assign w_ovf    = r_carry ^ slice_cout;
   assign w_is_sub = (in_op == OP_SUB) || (in_op == OP_SLT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      slice_a     = 1'b0;
      slice_b     = 1'b0;
      slice_cin   = 1'b0;
      slice_cntrl = 3'b000;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = in_op[2] ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            slice_a     = r_a[0];
            slice_b     = r_b[0];
            slice_cin   = r_carry;
            slice_cntrl = (r_op == OP_SLT) ? OP_SUB : r_op;
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_op     <= OP_ADD;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_err    <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
         r_ovf    <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a      <= in_a;
                  r_b      <= in_b;
                  r_op     <= in_op;
                  r_cnt    <= '0;
                  r_carry  <= w_is_sub;
                  r_result <= '0;
                  r_err    <= in_op[2];
`ifdef OVERFLOW_FLAG_EN
                  r_ovf    <= 1'b0;
`endif
               end
            end
            ST_RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= slice_cout;
               r_cnt   <= r_cnt + CNTW'(1);
               if (w_last && (r_op == OP_SLT)) begin
                  // Less-than is the sign of the difference, corrected for overflow.
                  r_result <= {{(WIDTH-1){1'b0}}, slice_out ^ w_ovf};
               end else begin
                  r_result <= {slice_out, r_result[WIDTH-1:1]};
               end
`ifdef OVERFLOW_FLAG_EN
               if (w_last) begin
                  r_ovf <= ((r_op == OP_ADD) || (r_op == OP_SUB)) && w_ovf;
               end
`endif
            end
            default: begin
            end
         endcase
      end
   end

   assign out_result = r_result;
   assign out_err    = r_err;
`ifdef OVERFLOW_FLAG_EN
   assign out_ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer: models the external slice and checks results against
// plain-arithmetic expectations for directed, random, reset-abort and backpressure scenarios.
module tb_alu_serial_sequencer;

   localparam int WIDTH = 32;
   localparam int CNTW  = 6;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_err;
   logic             slice_a;
   logic             slice_b;
   logic             slice_cin;
   logic [2:0]       slice_cntrl;
   logic             slice_out;
   logic             slice_cout;
`ifdef OVERFLOW_FLAG_EN
   logic             out_ovf;
`endif

   int checks = 0;
   int errors = 0;

   alu_serial_sequencer #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_op       (in_op),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_err     (out_err),
      .slice_a     (slice_a),
      .slice_b     (slice_b),
      .slice_cin   (slice_cin),
      .slice_cntrl (slice_cntrl),
      .slice_out   (slice_out),
      .slice_cout  (slice_cout)
`ifdef OVERFLOW_FLAG_EN
      ,
      .out_ovf     (out_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External 1-bit slice: full adder, B inverted for SUB, plain XOR for 010.
   logic w_bb;
   always_comb begin
      w_bb       = (slice_cntrl == 3'b001) ? ~slice_b : slice_b;
      slice_out  = (slice_cntrl == 3'b010) ? (slice_a ^ slice_b) : (slice_a ^ w_bb ^ slice_cin);
      slice_cout = (slice_a & w_bb) | (slice_a & slice_cin) | (w_bb & slice_cin);
   end

   function automatic void ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [2:0] op, output logic [WIDTH-1:0] r,
                                     output logic err, output logic ovf);
      r   = '0;
      err = 1'b0;
      ovf = 1'b0;
      case (op)
         3'b000: begin
            r   = a + b;
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         3'b001: begin
            r   = a - b;
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         end
         3'b010: r = a ^ b;
         3'b011: r = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
         default: err = 1'b1;
      endcase
   endfunction

   task automatic send_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
      int n;
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++;
      if (out_result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", out_result); end
      checks++;
      if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", out_err); end
      checks++;
      if ({slice_a, slice_b, slice_cin, slice_cntrl} !== 6'b0) begin
         errors++; $display("FAIL reset_slice got %b want 000000", {slice_a, slice_b, slice_cin, slice_cntrl});
      end
`ifdef OVERFLOW_FLAG_EN
      checks++;
      if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
`endif
   endtask

   task automatic test_directed();
      logic [WIDTH-1:0] va [7];
      logic [WIDTH-1:0] vb [7];
      logic [2:0]       vo [7];
      logic [WIDTH-1:0] er [7];
      logic [WIDTH-1:0] exp_r;
      logic             exp_e, exp_o;
      int               n, exp_lat;
      va = '{32'h0000_0005, 32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hA5A5_A5A5, 32'h1234_5678};
      vb = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_0000, 32'h1111_1111};
      vo = '{3'b000, 3'b001, 3'b000, 3'b011, 3'b011, 3'b010, 3'b101};
      er = '{32'h0000_0008, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h5A5A_A5A5, 32'h0000_0000};
      for (int i = 0; i < 7; i++) begin
         ref_model(va[i], vb[i], vo[i], exp_r, exp_e, exp_o);
         exp_lat = vo[i][2] ? 1 : WIDTH + 1;
         send_cmd(va[i], vb[i], vo[i]);
         wait_valid(n);
         checks++;
         if (n + 1 != exp_lat) begin
            errors++; $display("FAIL dir%0d_latency got %0d edges want %0d", i, n + 1, exp_lat);
         end
         checks++;
         if (out_result !== er[i]) begin
            errors++; $display("FAIL dir%0d_result got %h want %h", i, out_result, er[i]);
         end
         checks++;
         if (out_err !== vo[i][2]) begin
            errors++; $display("FAIL dir%0d_err got %b want %b", i, out_err, vo[i][2]);
         end
`ifdef OVERFLOW_FLAG_EN
         checks++;
         if (out_ovf !== exp_o) begin
            errors++; $display("FAIL dir%0d_ovf got %b want %b", i, out_ovf, exp_o);
         end
`endif
         release_result();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL dir%0d_return_idle got valid=%b ready=%b want 0/1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b, exp_r;
      logic [2:0]       op;
      logic             exp_e, exp_o;
      int               n, hold;
      for (int i = 0; i < 40; i++) begin
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 4) == 0) a = {1'b1, {(WIDTH-1){1'b0}}};
         if ($urandom_range(0, 4) == 0) b = {1'b0, {(WIDTH-1){1'b1}}};
         op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         ref_model(a, b, op, exp_r, exp_e, exp_o);
         send_cmd(a, b, op);
         wait_valid(n);
         hold = $urandom_range(0, 3);
         repeat (hold) begin
            @(posedge clk); #1;
         end
         checks++;
         if (out_valid !== 1'b1 || out_result !== exp_r || out_err !== exp_e) begin
            errors++;
            $display("FAIL rnd%0d op=%b a=%h b=%h got v=%b r=%h e=%b want v=1 r=%h e=%b",
                     i, op, a, b, out_valid, out_result, out_err, exp_r, exp_e);
         end
`ifdef OVERFLOW_FLAG_EN
         checks++;
         if (out_ovf !== exp_o) begin
            errors++; $display("FAIL rnd%0d_ovf got %b want %b", i, out_ovf, exp_o);
         end
`endif
         release_result();
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      send_cmd({WIDTH{1'b1}}, {WIDTH{1'b1}}, 3'b001);
      repeat (5) begin
         @(posedge clk); #1;
      end
      checks++;
      if (slice_cntrl !== 3'b001 || in_ready !== 1'b0) begin
         errors++; $display("FAIL midrun_active got cntrl=%b ready=%b want 001/0", slice_cntrl, in_ready);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL midrun_reset_hs got ready=%b valid=%b want 1/0", in_ready, out_valid);
      end
      checks++;
      if ({slice_a, slice_b, slice_cin, slice_cntrl} !== 6'b0) begin
         errors++; $display("FAIL midrun_reset_slice got %b want 000000", {slice_a, slice_b, slice_cin, slice_cntrl});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_cmd(32'h0000_0005, 32'h0000_0003, 3'b000);
      wait_valid(n);
      checks++;
      if (n + 1 != WIDTH + 1 || out_result !== 32'h0000_0008 || out_err !== 1'b0) begin
         errors++; $display("FAIL after_reset_add got lat=%0d r=%h e=%b want lat=%0d r=00000008 e=0",
                            n + 1, out_result, out_err, WIDTH + 1);
      end
      release_result();
   endtask

   task automatic test_backpressure();
      int n;
      send_cmd(32'h1000_0000, 32'h0000_00FF, 3'b000);
      wait_valid(n);
      in_a     = 32'h0000_0010;
      in_b     = 32'h0000_0004;
      in_op    = 3'b001;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'h1000_00FF) begin
            errors++; $display("FAIL bp_hold%0d got v=%b rdy=%b r=%h want 1/0/100000ff",
                               i, out_valid, in_ready, out_result);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_second_accept got rdy=%b want 0", in_ready);
      end
      wait_valid(n);
      checks++;
      if (n != WIDTH || out_result !== 32'h0000_000C || out_err !== 1'b0) begin
         errors++; $display("FAIL bp_second_result got lat=%0d r=%h e=%b want lat=%0d r=0000000c e=0",
                            n, out_result, out_err, WIDTH);
      end
      release_result();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_op     = 3'b000;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_directed();
      test_random();
      test_reset_mid_run();
      test_backpressure();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
